// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: address widths, NOP encoding, fetch
// FSM state encodings and a word-alignment helper.
package mips_defs_pkg;

   localparam int PC_W    = 32;
   localparam int WADDR_W = 30;

   // sll $0,$0,0 -- the canonical all-zero MIPS NOP
   localparam logic [PC_W-1:0] NOP_ENC = 32'h0000_0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } if_state_e;

   // Clear the byte-offset bits so a PC always points at a whole word
   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mod_pc_register.sv
// Program counter for the IF stage: PC flop, next-PC selection
// (redirect / +4 / hold), alignment masking of redirect targets and the
// sticky misalignment flag.
module mod_pc_register
   import mips_defs_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            advance,
   output logic [PC_W-1:0] pc,
   output logic            misalign_err
);

   // Redirect beats sequential advance; PC+4 wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else if (redirect_valid) begin
         pc <= word_align(redirect_pc);
         if (|redirect_pc[1:0]) begin
            misalign_err <= 1'b1;
         end
      end else if (advance) begin
         pc <= pc + PC_W'(4);
      end
   end

endmodule

// File: rtl/mod_instruction_fetch.sv
// MIPS IF stage: owns the PC (via mod_pc_register), addresses the
// instruction ROM and fills the IF/ID pipeline register. Handles stall,
// flush, branch/jump redirects and halts at the end of the program.
// Optional macro IF_PERF_CNT_EN adds a fetch_count output counting every
// real instruction loaded into IF/ID.
module mod_instruction_fetch
   import mips_defs_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [PC_W-1:0] NOP_WORD = NOP_ENC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [WADDR_W-1:0] imem_addr,
   input  logic [PC_W-1:0]    imem_instruction,
   input  logic               imem_end,
   output logic [PC_W-1:0]    if_id_instruction,
   output logic [PC_W-1:0]    if_id_pc4,
   output logic               if_id_valid,
   output logic               halted,
   output logic               misalign_err
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count
`endif
);

   logic [PC_W-1:0] pc;
   if_state_e       state;
   logic            advance;
   logic            load_en;
   logic [PC_W-1:0] instr_p1;
   logic [PC_W-1:0] pc4_p1;
   logic            vld_p1;

   // PC moves on only when running, not stalled and still inside the program;
   // a flush bubbles IF/ID but does not stop the PC from advancing.
   assign advance = !redirect_valid && (state == ST_RUN) && !stall && !imem_end;
   assign load_en = advance && !flush;

   mod_pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance),
      .pc             (pc),
      .misalign_err   (misalign_err)
   );

   assign imem_addr         = pc[PC_W-1:2];
   assign if_id_instruction = instr_p1;
   assign if_id_pc4         = pc4_p1;
   assign if_id_valid       = vld_p1;
   assign halted            = (state == ST_HALT);

   // IF/ID register and RUN/HALT control; a bubble keeps the old pc4 value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         instr_p1 <= NOP_WORD;
         pc4_p1   <= '0;
         vld_p1   <= 1'b0;
      end else if (redirect_valid) begin
         instr_p1 <= NOP_WORD;
         vld_p1   <= 1'b0;
         state    <= ST_RUN;
      end else if (flush) begin
         instr_p1 <= NOP_WORD;
         vld_p1   <= 1'b0;
      end else if (stall) begin
         instr_p1 <= instr_p1;
      end else if (state == ST_RUN) begin
         if (imem_end) begin
            instr_p1 <= NOP_WORD;
            vld_p1   <= 1'b0;
            state    <= ST_HALT;
         end else begin
            instr_p1 <= imem_instruction;
            pc4_p1   <= pc + PC_W'(4);
            vld_p1   <= 1'b1;
         end
      end else begin
         instr_p1 <= NOP_WORD;
         vld_p1   <= 1'b0;
      end
   end

`ifdef IF_PERF_CNT_EN
   // Count every edge that places a real instruction into IF/ID
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (load_en) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Scoreboard bench for mod_instruction_fetch: directed scenarios from the
// program 0x20050005 / 0x20060001 / 0x00A62022 followed by randomized
// stall/flush/redirect traffic against a rule-level reference model.
module tb_mod_instruction_fetch;

   localparam logic [31:0] NOP    = 32'h0000_0020;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [29:0] imem_addr;
   logic [31:0] imem_instruction;
   logic        imem_end;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic        misalign_err;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   int checks = 0;
   int errors = 0;

   // ROM environment: either a finite program or an "open" address space
   logic [31:0] rom [0:15];
   int          rom_len = 3;
   bit          rom_open = 1'b0;

   assign imem_end = rom_open ? 1'b0 : (32'(imem_addr) >= rom_len);
   assign imem_instruction = rom_open ? {imem_addr, 2'b11} :
                             ((32'(imem_addr) < rom_len) ? rom[imem_addr[3:0]] : 32'hBAD0_0000);

   mod_instruction_fetch #(
      .RESET_PC (RST_PC),
      .NOP_WORD (NOP)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall             (stall),
      .flush             (flush),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_addr         (imem_addr),
      .imem_instruction  (imem_instruction),
      .imem_end          (imem_end),
      .if_id_instruction (if_id_instruction),
      .if_id_pc4         (if_id_pc4),
      .if_id_valid       (if_id_valid),
      .halted            (halted),
      .misalign_err      (misalign_err)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_count       (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halted;
      logic        mis;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
   bit          m_valid, m_halt, m_mis;

   function automatic logic [31:0] rom_word(input logic [31:0] byte_pc);
      logic [29:0] a;
      a = byte_pc[31:2];
      if (rom_open) return {a, 2'b11};
      if (32'(a) < rom_len) return rom[a[3:0]];
      return 32'hBAD0_0000;
   endfunction

   function automatic bit rom_end(input logic [31:0] byte_pc);
      if (rom_open) return 1'b0;
      return (32'(byte_pc[31:2]) >= rom_len);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
   endtask

   // One clock edge of the IF stage, written straight from the priority rules
   task automatic model_step(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
      bit          at_end;
      logic [31:0] word;
      at_end = rom_end(m_pc);
      word   = rom_word(m_pc);
      if (rv) begin
         m_pc = rpc & ~32'd3;
         m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
         if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else if (fl) begin
         m_instr = NOP; m_valid = 1'b0;
         if (!m_halt && !st && !at_end) m_pc = m_pc + 32'd4;
      end else if (st) begin
         // everything holds
      end else if (!m_halt && at_end) begin
         m_instr = NOP; m_valid = 1'b0; m_halt = 1'b1;
      end else if (!m_halt) begin
         m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
         m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end else begin
         m_instr = NOP; m_valid = 1'b0;
      end
   endtask

   // Drive one cycle: inputs set just after the falling edge, expectation queued,
   // returns 1 time unit after the next falling edge (monitor has compared).
   task automatic cycle(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
      exp_t e;
      stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
      model_step(st, fl, rv, rpc);
      e.addr = m_pc[31:2]; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
      e.halted = m_halt; e.mis = m_mis; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("imem_addr", 32'(imem_addr), 32'(e.addr));
         chk("if_id_instruction", if_id_instruction, e.instr);
         chk("if_id_pc4", if_id_pc4, e.pc4);
         chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
         chk("halted", 32'(halted), 32'(e.halted));
         chk("misalign_err", 32'(misalign_err), 32'(e.mis));
`ifdef IF_PERF_CNT_EN
         chk("fetch_count", fetch_count, e.cnt);
`endif
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_addr"}, 32'(imem_addr), 32'(RST_PC[31:2]));
      chk({tag, "_instr"}, if_id_instruction, NOP);
      chk({tag, "_pc4"}, if_id_pc4, 32'h0);
      chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
      chk({tag, "_mis"}, 32'(misalign_err), 32'h0);
`ifdef IF_PERF_CNT_EN
      chk({tag, "_count"}, fetch_count, 32'h0);
`endif
   endtask

   initial begin
      rom[0] = 32'h2005_0005; rom[1] = 32'h2006_0001; rom[2] = 32'h00A6_2022;
      for (int i = 3; i < 16; i++) rom[i] = 32'h0;
      model_reset();

      // Power-on reset
      #1 rst_n = 1'b0;
      #1 check_reset_values("por");
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // Test 1: straight-line fetch to end of program
      cycle(0, 0, 0, 0);
      chk("t1_i0", if_id_instruction, 32'h2005_0005);
      chk("t1_pc4_0", if_id_pc4, 32'd4);
      cycle(0, 0, 0, 0);
      chk("t1_i1", if_id_instruction, 32'h2006_0001);
      cycle(0, 0, 0, 0);
      chk("t1_i2", if_id_instruction, 32'h00A6_2022);
      chk("t1_pc4_2", if_id_pc4, 32'd12);
      cycle(0, 0, 0, 0);
      chk("t1_halted", 32'(halted), 32'd1);
      chk("t1_valid", 32'(if_id_valid), 32'd0);
      chk("t1_addr", 32'(imem_addr), 32'd3);
`ifdef IF_PERF_CNT_EN
      chk("t1_count", fetch_count, 32'd3);
`endif
      cycle(0, 0, 0, 0);
      chk("t1_addr_hold", 32'(imem_addr), 32'd3);

      // Test 3: redirect out of HALT
      cycle(0, 0, 1, 32'h4);
      chk("t3_halted", 32'(halted), 32'd0);
      chk("t3_addr", 32'(imem_addr), 32'd1);
      cycle(0, 0, 0, 0);
      chk("t3_instr", if_id_instruction, 32'h2006_0001);
      chk("t3_pc4", if_id_pc4, 32'd8);

      // Test 2: stall after the first fetch
      cycle(0, 0, 1, 32'h0);
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("t2_instr", if_id_instruction, 32'h2005_0005);
      chk("t2_addr", 32'(imem_addr), 32'd1);
      cycle(0, 0, 0, 0);
      chk("t2_resume", if_id_instruction, 32'h2006_0001);

      // Test 4: stall and flush together
      cycle(0, 0, 1, 32'h4);
      cycle(1, 1, 0, 0);
      chk("t4_valid", 32'(if_id_valid), 32'd0);
      chk("t4_instr", if_id_instruction, NOP);
      chk("t4_addr", 32'(imem_addr), 32'd1);

      // Test 5: misaligned redirect, sticky flag
      cycle(0, 0, 1, 32'h6);
      chk("t5_mis", 32'(misalign_err), 32'd1);
      chk("t5_addr", 32'(imem_addr), 32'd1);
      cycle(0, 0, 1, 32'h0);
      cycle(0, 0, 0, 0);
      chk("t5_sticky", 32'(misalign_err), 32'd1);

      // Test 6: asynchronous reset between clock edges at imem_addr=2
      cycle(0, 0, 0, 0);
      chk("t6_pre_addr", 32'(imem_addr), 32'd2);
      #2 rst_n = 1'b0;
      #1 check_reset_values("async");
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // PC wrap at 2^32 using an open address space
      rom_open = 1'b1;
      cycle(0, 0, 1, 32'hFFFF_FFF8);
      cycle(0, 0, 0, 0);
      chk("wrap_pc4_hi", if_id_pc4, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0);
      chk("wrap_pc4_zero", if_id_pc4, 32'h0);
      chk("wrap_addr", 32'(imem_addr), 32'h0);
      rom_open = 1'b0;

      // Randomized traffic over a 12-word program
      rom_len = 12;
      for (int i = 0; i < 12; i++) rom[i] = $urandom;
      cycle(0, 0, 1, 32'h0);
      for (int n = 0; n < 600; n++) begin
         bit          st, fl, rv;
         logic [31:0] tgt;
         st  = ($urandom_range(0, 9) < 2);
         fl  = ($urandom_range(0, 9) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         tgt = 32'($urandom_range(0, 15)) * 32'd4;
         if ($urandom_range(0, 7) == 0) tgt = tgt + 32'($urandom_range(1, 3));
         cycle(st, fl, rv, tgt);
      end

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
